// File: rtl/imem_program_loader_pkg.sv
// Shared constants for the instruction-memory program loader: host command bytes,
// legacy 3-bit state encodings, and a helper that decodes the load-in-progress states.
package imem_program_loader_pkg;

   // Host command bytes
   localparam logic [7:0] LDR_CMD_LOAD = 8'h4C;  // 'L'
   localparam logic [7:0] LDR_CMD_RUN  = 8'h52;  // 'R'

   // Loader state encodings
   localparam logic [2:0] LDR_ST_IDLE   = 3'd0;
   localparam logic [2:0] LDR_ST_CNT_HI = 3'd1;
   localparam logic [2:0] LDR_ST_CNT_LO = 3'd2;
   localparam logic [2:0] LDR_ST_DATA   = 3'd3;
   localparam logic [2:0] LDR_ST_CHK    = 3'd4;
   localparam logic [2:0] LDR_ST_RUN    = 3'd5;
   localparam logic [2:0] LDR_ST_HALTED = 3'd6;
   localparam logic [2:0] LDR_ST_ERR    = 3'd7;

   // A load is in progress from the count header through the check step
   function automatic logic ldr_st_busy(input logic [2:0] st);
      return (st >= LDR_ST_CNT_HI) && (st <= LDR_ST_CHK);
   endfunction

endpackage

// File: rtl/imem_program_loader_word_assembler.sv
// Packs a byte stream MSB-first into 32-bit words.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   i_clear          discards any partial word (held while not receiving data)
//   i_byte_valid     a byte is presented on i_byte this cycle
//   i_byte           incoming byte
//   o_word_c         {three stored bytes, i_byte}; meaningful while o_word_valid_c
//   o_word_valid_c   the current byte completes a word
module imem_program_loader_word_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_clear,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word_c,
   output logic        o_word_valid_c
);

   logic [1:0]  r_idx;
   logic [23:0] r_shift;

   assign o_word_c       = {r_shift, i_byte};
   assign o_word_valid_c = i_byte_valid && !i_clear && (r_idx == 2'd3);

   // Byte index and shift register; wraps naturally after the fourth byte
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idx   <= 2'd0;
         r_shift <= 24'd0;
      end else if (i_clear) begin
         r_idx   <= 2'd0;
         r_shift <= 24'd0;
      end else if (i_byte_valid) begin
         r_idx   <= r_idx + 2'd1;
         r_shift <= {r_shift[15:0], i_byte};
      end
   end

endmodule

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader: receives a host byte stream, assembles big-endian
// words into instruction memory, holds the core in reset while loading, then releases it
// and watches for halt.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing 8-bit sum byte verified after data).
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   i_rx_data/i_rx_valid       host byte stream; accepted when i_rx_valid && o_rx_ready
//   o_rx_ready                 byte acceptance (always 1 out of reset)
//   i_cpu_halt                 core halt indication
//   o_imem_we/addr/wdata       instruction-memory write port
//   o_cpu_reset                active-high core reset
//   o_busy, o_halted, o_error  status
module imem_program_loader
   import imem_program_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   output logic              o_rx_ready,
   input  logic              i_cpu_halt,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [31:0]       o_imem_wdata,
   output logic              o_cpu_reset,
   output logic              o_busy,
   output logic              o_halted,
   output logic              o_error
);

   logic [2:0]        r_state, w_state_nx;
   logic              r_rx_ready;
   logic              r_cpu_reset, w_cpu_reset_nx;
   logic              r_busy, w_busy_nx;
   logic              r_halted, w_halted_nx;
   logic              r_error, w_error_nx;
   logic              r_we, w_we_nx;
   logic [ADDR_W-1:0] r_addr, w_addr_nx;
   logic [31:0]       r_wdata, w_wdata_nx;
   logic [7:0]        r_cnt_hi, w_cnt_hi_nx;
   logic [15:0]       r_count, w_count_nx;
   logic [15:0]       r_word_idx, w_word_idx_nx;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        r_sum, w_sum_nx;
`endif

   logic        w_accept;
   logic [15:0] w_n;
   logic [31:0] w_word_c;
   logic        w_word_valid_c;

   assign w_accept = i_rx_valid && r_rx_ready;
   assign w_n      = {r_cnt_hi, i_rx_data};

   // Assembler only runs in DATA so every load starts word-aligned
   imem_program_loader_word_assembler u_asm (
      .clk           (clk),
      .reset         (reset),
      .i_clear       (r_state != LDR_ST_DATA),
      .i_byte_valid  (w_accept),
      .i_byte        (i_rx_data),
      .o_word_c      (w_word_c),
      .o_word_valid_c(w_word_valid_c)
   );

   // Next-state and next-output logic
   always_comb begin
      w_state_nx    = r_state;
      w_error_nx    = r_error;
      w_we_nx       = 1'b0;
      w_addr_nx     = r_addr;
      w_wdata_nx    = r_wdata;
      w_cnt_hi_nx   = r_cnt_hi;
      w_count_nx    = r_count;
      w_word_idx_nx = r_word_idx;
`ifdef LOADER_CHECKSUM_EN
      w_sum_nx      = r_sum;
`endif

      case (r_state)
         LDR_ST_IDLE, LDR_ST_RUN, LDR_ST_HALTED, LDR_ST_ERR: begin
            // A load command takes priority over a coincident halt
            if (w_accept && (i_rx_data == LDR_CMD_LOAD)) begin
               w_state_nx = LDR_ST_CNT_HI;
               w_error_nx = 1'b0;
`ifdef LOADER_CHECKSUM_EN
               w_sum_nx   = 8'd0;
`endif
            end else if (w_accept && (i_rx_data == LDR_CMD_RUN) &&
                         ((r_state == LDR_ST_IDLE) || (r_state == LDR_ST_ERR))) begin
               w_state_nx = LDR_ST_RUN;
            end else if ((r_state == LDR_ST_RUN) && i_cpu_halt) begin
               w_state_nx = LDR_ST_HALTED;
            end
         end
         LDR_ST_CNT_HI: begin
            if (w_accept) begin
               w_cnt_hi_nx = i_rx_data;
               w_state_nx  = LDR_ST_CNT_LO;
            end
         end
         LDR_ST_CNT_LO: begin
            if (w_accept) begin
               w_count_nx    = w_n;
               w_word_idx_nx = 16'd0;
               // Oversized images are rejected here so the address never wraps
               if (32'(w_n) > DEPTH) begin
                  w_state_nx = LDR_ST_ERR;
                  w_error_nx = 1'b1;
               end else if (w_n == 16'd0) begin
                  w_state_nx = LDR_ST_CHK;
               end else begin
                  w_state_nx = LDR_ST_DATA;
               end
            end
         end
         LDR_ST_DATA: begin
`ifdef LOADER_CHECKSUM_EN
            if (w_accept) w_sum_nx = r_sum + i_rx_data;
`endif
            if (w_word_valid_c) begin
               w_we_nx       = 1'b1;
               w_addr_nx     = ADDR_W'(r_word_idx);
               w_wdata_nx    = w_word_c;
               w_word_idx_nx = r_word_idx + 16'd1;
               if (r_word_idx == (r_count - 16'd1)) w_state_nx = LDR_ST_CHK;
            end
         end
         LDR_ST_CHK: begin
`ifdef LOADER_CHECKSUM_EN
            if (w_accept) begin
               if (i_rx_data == r_sum) begin
                  w_state_nx = LDR_ST_RUN;
               end else begin
                  w_state_nx = LDR_ST_ERR;
                  w_error_nx = 1'b1;
               end
            end
`else
            w_state_nx = LDR_ST_RUN;
`endif
         end
         default: w_state_nx = LDR_ST_IDLE;
      endcase

      // Status outputs follow the destination state so they change on the transition edge
      w_busy_nx      = ldr_st_busy(w_state_nx);
      w_halted_nx    = (w_state_nx == LDR_ST_HALTED);
      w_cpu_reset_nx = !((w_state_nx == LDR_ST_RUN) || (w_state_nx == LDR_ST_HALTED));
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= LDR_ST_IDLE;
         r_rx_ready  <= 1'b0;
         r_cpu_reset <= 1'b1;
         r_busy      <= 1'b0;
         r_halted    <= 1'b0;
         r_error     <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= 32'd0;
         r_cnt_hi    <= 8'd0;
         r_count     <= 16'd0;
         r_word_idx  <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
         r_sum       <= 8'd0;
`endif
      end else begin
         r_state     <= w_state_nx;
         r_rx_ready  <= 1'b1;
         r_cpu_reset <= w_cpu_reset_nx;
         r_busy      <= w_busy_nx;
         r_halted    <= w_halted_nx;
         r_error     <= w_error_nx;
         r_we        <= w_we_nx;
         r_addr      <= w_addr_nx;
         r_wdata     <= w_wdata_nx;
         r_cnt_hi    <= w_cnt_hi_nx;
         r_count     <= w_count_nx;
         r_word_idx  <= w_word_idx_nx;
`ifdef LOADER_CHECKSUM_EN
         r_sum       <= w_sum_nx;
`endif
      end
   end

   assign o_rx_ready   = r_rx_ready;
   assign o_cpu_reset  = r_cpu_reset;
   assign o_busy       = r_busy;
   assign o_halted     = r_halted;
   assign o_error      = r_error;
   assign o_imem_we    = r_we;
   assign o_imem_addr  = r_addr;
   assign o_imem_wdata = r_wdata;

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: directed protocol cases followed by
// randomized command/frame traffic, compared every cycle against a frame-level model.
module tb_imem_program_loader;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DEPTH  = 1024;

   logic              clk;
   logic              reset;
   logic [7:0]        i_rx_data;
   logic              i_rx_valid;
   logic              o_rx_ready;
   logic              i_cpu_halt;
   logic              o_imem_we;
   logic [ADDR_W-1:0] o_imem_addr;
   logic [31:0]       o_imem_wdata;
   logic              o_cpu_reset;
   logic              o_busy;
   logic              o_halted;
   logic              o_error;

   imem_program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .i_rx_data   (i_rx_data),
      .i_rx_valid  (i_rx_valid),
      .o_rx_ready  (o_rx_ready),
      .i_cpu_halt  (i_cpu_halt),
      .o_imem_we   (o_imem_we),
      .o_imem_addr (o_imem_addr),
      .o_imem_wdata(o_imem_wdata),
      .o_cpu_reset (o_cpu_reset),
      .o_busy      (o_busy),
      .o_halted    (o_halted),
      .o_error     (o_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   // Tracks position within a load frame rather than any state encoding.
   bit          m_loading, m_in_chk, m_core_on, m_halted, m_err;
   int          m_pos, m_n;
   logic [7:0]  m_sum;
   logic [31:0] m_word;
   // expected DUT outputs after the coming clock edge
   logic              e_rx_ready, e_cpu_reset, e_busy, e_halted, e_error, e_we;
   logic [ADDR_W-1:0] e_addr;
   logic [31:0]       e_wdata;

   function automatic void model_reset();
      m_loading = 0; m_in_chk = 0; m_core_on = 0; m_halted = 0; m_err = 0;
      m_pos = 0; m_n = 0; m_sum = 8'd0; m_word = 32'd0;
      e_rx_ready = 0; e_cpu_reset = 1; e_busy = 0; e_halted = 0; e_error = 0;
      e_we = 0; e_addr = '0; e_wdata = 32'd0;
   endfunction

   function automatic void model_step(input logic v, input logic [7:0] b, input logic h);
      bit acc;
      int k;
      if (!reset) begin
         model_reset();
         return;
      end
      acc  = v && e_rx_ready;
      e_we = 1'b0;
      if (m_loading) begin
         if (m_in_chk) begin
`ifdef LOADER_CHECKSUM_EN
            if (acc) begin
               m_loading = 0; m_in_chk = 0;
               if (b == m_sum) m_core_on = 1; else m_err = 1;
            end
`else
            m_loading = 0; m_in_chk = 0; m_core_on = 1;
`endif
         end else if (acc) begin
            if (m_pos == 0) begin
               m_n = 32'(b) * 256;
            end else if (m_pos == 1) begin
               m_n = m_n + 32'(b);
               if (m_n > 32'(DEPTH)) begin
                  m_loading = 0; m_err = 1;
               end else if (m_n == 0) begin
                  m_in_chk = 1;
               end
            end else begin
               k      = m_pos - 2;
               m_word = {m_word[23:0], b};
               m_sum  = m_sum + b;
               if (k % 4 == 3) begin
                  e_we    = 1'b1;
                  e_addr  = ADDR_W'(k / 4);
                  e_wdata = m_word;
                  if (k / 4 == m_n - 1) m_in_chk = 1;
               end
            end
            m_pos++;
         end
      end else if (acc && b == 8'h4C) begin
         m_loading = 1; m_in_chk = 0; m_pos = 0; m_sum = 8'd0;
         m_core_on = 0; m_halted = 0; m_err = 0;
      end else if (acc && b == 8'h52 && !m_core_on) begin
         m_core_on = 1;
      end else if (m_core_on && !m_halted && h) begin
         m_halted = 1;
      end
      e_rx_ready  = 1'b1;
      e_cpu_reset = !m_core_on;
      e_busy      = m_loading;
      e_halted    = m_halted;
      e_error     = m_err;
   endfunction

   // ---------------- compare process ----------------
   logic [31:0] dut_mem [0:DEPTH-1];

   always @(negedge clk) begin
      chk("rx_ready",  32'(o_rx_ready),  32'(e_rx_ready));
      chk("cpu_reset", 32'(o_cpu_reset), 32'(e_cpu_reset));
      chk("busy",      32'(o_busy),      32'(e_busy));
      chk("halted",    32'(o_halted),    32'(e_halted));
      chk("error",     32'(o_error),     32'(e_error));
      chk("imem_we",   32'(o_imem_we),   32'(e_we));
      chk("imem_addr", 32'(o_imem_addr), 32'(e_addr));
      chk("imem_wdata", o_imem_wdata,    e_wdata);
      if (o_imem_we === 1'b1) dut_mem[o_imem_addr] <= o_imem_wdata;
   end

   // ---------------- stimulus helpers ----------------
   logic [7:0] tb_sum;

   task automatic cycle(input logic v, input logic [7:0] d, input logic h);
      @(negedge clk);
      #1;
      i_rx_valid = v;
      i_rx_data  = d;
      i_cpu_halt = h;
      model_step(v, d, h);
   endtask

   task automatic rst_cycle(input logic r);
      @(negedge clk);
      #1;
      reset      = r;
      i_rx_valid = 1'b0;
      i_rx_data  = 8'd0;
      i_cpu_halt = 1'b0;
      model_step(1'b0, 8'd0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 1'b0);
   endtask

   task automatic send(input logic [7:0] b, input int max_gap);
      int g;
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int i = 0; i < g; i++) cycle(1'b0, 8'($urandom), $urandom_range(0, 7) == 0);
      cycle(1'b1, b, 1'b0);
   endtask

   task automatic send_hdr(input int n, input int gap);
      tb_sum = 8'd0;
      send(8'h4C, gap);
      send(8'(n >> 8), gap);
      send(8'(n), gap);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      logic [31:0] t;
      t = w;
      for (int i = 0; i < 4; i++) begin
         tb_sum = tb_sum + t[31:24];
         send(t[31:24], gap);
         t = t << 8;
      end
   endtask

   // Trailing checksum byte; 'bad' corrupts it
   task automatic send_sum(input bit bad, input int gap);
`ifdef LOADER_CHECKSUM_EN
      send(bad ? tb_sum + 8'd1 : tb_sum, gap);
`else
      if (bad) idle(gap);
      else idle(0);
`endif
   endtask

   // ---------------- test sequence ----------------
   initial begin
      reset      = 1'b0;
      i_rx_valid = 1'b0;
      i_rx_data  = 8'd0;
      i_cpu_halt = 1'b0;
      tb_sum     = 8'd0;
      model_reset();

      rst_cycle(1'b0);
      rst_cycle(1'b0);
      chk("lit_rst_cpu_reset", 32'(o_cpu_reset), 32'd1);
      chk("lit_rst_we",        32'(o_imem_we),   32'd0);
      chk("lit_rst_error",     32'(o_error),     32'd0);
      chk("lit_rst_rx_ready",  32'(o_rx_ready),  32'd0);
      rst_cycle(1'b1);
      idle(2);
      chk("lit_rx_ready_after", 32'(o_rx_ready), 32'd1);

      // 'R' releases the core without loading
      send(8'h52, 0);
      idle(1);
      chk("lit_R_cpu_reset", 32'(o_cpu_reset), 32'd0);

      // Two-word load
      send_hdr(2, 0);
      send_word(32'h12345678, 0);
      send_word(32'h9ABCDEF0, 0);
      send_sum(1'b0, 0);
      idle(3);
      chk("lit_word0", dut_mem[0], 32'h12345678);
      chk("lit_word1", dut_mem[1], 32'h9ABCDEF0);
      chk("lit_load_released", 32'(o_cpu_reset), 32'd0);

      // Oversized count is rejected
      send_hdr(1025, 0);
      idle(2);
      chk("lit_ovf_error", 32'(o_error),     32'd1);
      chk("lit_ovf_held",  32'(o_cpu_reset), 32'd1);

`ifdef LOADER_CHECKSUM_EN
      send_hdr(1, 0);
      send_word(32'h01020304, 0);
      send(8'hFF, 0);
      idle(1);
      chk("lit_badsum_error", 32'(o_error),     32'd1);
      chk("lit_badsum_held",  32'(o_cpu_reset), 32'd1);
      send_hdr(1, 0);
      send_word(32'h01020304, 0);
      send(8'h0A, 0);
      idle(1);
      chk("lit_goodsum_run",  32'(o_cpu_reset), 32'd0);
`else
      send(8'h52, 0);
      idle(1);
`endif

      // Halt, then reload while halted
      cycle(1'b0, 8'd0, 1'b1);
      idle(1);
      chk("lit_halted", 32'(o_halted), 32'd1);
      send(8'h4C, 0);
      idle(1);
      chk("lit_L_cpu_reset", 32'(o_cpu_reset), 32'd1);
      chk("lit_L_halted",    32'(o_halted),    32'd0);
      chk("lit_L_busy",      32'(o_busy),      32'd1);
      send(8'h00, 0);
      send(8'h00, 0);
      tb_sum = 8'd0;
      send_sum(1'b0, 0);
      idle(2);

      // Reset in the middle of a word
      send_hdr(1, 0);
      send(8'hAA, 0);
      send(8'hBB, 0);
      rst_cycle(1'b0);
      rst_cycle(1'b0);
      chk("lit_midrst_busy", 32'(o_busy),      32'd0);
      chk("lit_midrst_cpu",  32'(o_cpu_reset), 32'd1);
      chk("lit_midrst_addr", 32'(o_imem_addr), 32'd0);
      rst_cycle(1'b1);
      idle(1);
      send_hdr(1, 0);
      send_word(32'hAABBCCDD, 0);
      send_sum(1'b0, 0);
      idle(3);
      chk("lit_after_rst_word", dut_mem[0], 32'hAABBCCDD);
      chk("lit_after_rst_run",  32'(o_cpu_reset), 32'd0);

      // Randomized traffic
      for (int it = 0; it < 150; it++) begin
         int sel;
         int n;
         sel = int'($urandom_range(0, 9));
         case (sel)
            0, 1, 2, 3: begin
               n = int'($urandom_range(0, 4));
               send_hdr(n, 2);
               for (int w = 0; w < n; w++) send_word($urandom, 2);
               send_sum($urandom_range(0, 3) == 0, 2);
            end
            4: begin
               if ($urandom_range(0, 1) == 0) n = 1025 + int'($urandom_range(0, 60000));
               else n = 1024;
               send_hdr(n, 1);
               if (n == 1024) begin
                  // abandon the frame with a reset rather than send 4 KiB
                  send($urandom, 1);
                  rst_cycle(1'b0);
                  rst_cycle(1'b1);
               end
            end
            5: send(8'h52, 2);
            6: send(8'($urandom), 2);
            7: begin
               n = int'($urandom_range(1, 3));
               for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 1'b1);
            end
            8: idle(int'($urandom_range(1, 4)));
            default: begin
               send_hdr(2, 1);
               n = int'($urandom_range(0, 6));
               for (int i = 0; i < n; i++) send(8'($urandom), 1);
               rst_cycle(1'b0);
               if ($urandom_range(0, 1) == 1) rst_cycle(1'b0);
               rst_cycle(1'b1);
            end
         endcase
      end
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
